// File: rtl/multicycle_shifter.sv
// Multicycle shifter: one 1-bit shift per clock, done pulse on completion.
// Optional rotate-left for mode 11 via MULTICYCLE_SHIFTER_ROTATE_EN.
module multicycle_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    by,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             shifted_out
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
  localparam logic [1:0] MODE_ROL = 2'b11;
`endif

  // Encoding chosen so busy/done are direct state flop bits.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [1:0]       mode_r;
  logic [SW-1:0]    count;
  logic [WIDTH-1:0] q_step;
  logic             out_step;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (by != '0) ? SHIFT : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (count == SW'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state flops
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // One-bit operation on Q selected by the latched mode
  always_comb begin
    q_step   = {Q[WIDTH-2:0], 1'b0};
    out_step = Q[WIDTH-1];
    case (mode_r)
      MODE_LSR: begin
        q_step   = {1'b0, Q[WIDTH-1:1]};
        out_step = Q[0];
      end
      MODE_ASR: begin
        q_step   = {Q[WIDTH-1], Q[WIDTH-1:1]};
        out_step = Q[0];
      end
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
      MODE_ROL: begin
        q_step   = {Q[WIDTH-2:0], Q[WIDTH-1]};
        out_step = Q[WIDTH-1];
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      Q           <= '0;
      shifted_out <= 1'b0;
      count       <= '0;
      mode_r      <= MODE_LSL;
    end else if (accept) begin
      Q           <= D;
      shifted_out <= 1'b0;
      count       <= by;
      mode_r      <= mode;
    end else if (state == SHIFT) begin
      Q           <= q_step;
      shifted_out <= out_step;
      count       <= count - SW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed self-checking bench for multicycle_shifter at WIDTH=8.
module tb_multicycle_shifter;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [2:0] by;
  logic [7:0] D;
  logic [7:0] Q;
  logic       busy;
  logic       done;
  logic       shifted_out;

  int vectors;
  int miscompares;

  multicycle_shifter #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .by(by),
    .D(D), .Q(Q), .busy(busy), .done(done), .shifted_out(shifted_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [2:0] b, input logic [7:0] d);
    start = 1'b1; mode = m; by = b; D = d;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 2'b00; by = 3'd0; D = 8'h00;
    step(); step();
    vectors++;
    if ({Q, busy, done, shifted_out} !== {8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset: Q=%h busy=%b done=%b out=%b, need 00 0 0 0", Q, busy, done, shifted_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lsl();
    int bc;
    logic [7:0] exp_q [3] = '{8'h62, 8'hC4, 8'h88};
    logic       exp_o [3] = '{1'b1, 1'b0, 1'b1};
    issue(2'b00, 3'd3, 8'b1011_0001);
    bc = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) bc++;
      step();
      vectors++;
      if (Q !== exp_q[i] || shifted_out !== exp_o[i]) begin
        miscompares++;
        $display("FAIL lsl_step%0d: Q=%h out=%b, need %h %b", i, Q, shifted_out, exp_q[i], exp_o[i]);
      end
    end
    vectors++;
    if (bc != 3 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lsl_timing: busy_cycles=%0d done=%b busy=%b, need 3 1 0", bc, done, busy);
    end
    step();
    vectors++;
    if (done !== 1'b0 || Q !== 8'h88 || shifted_out !== 1'b1) begin
      miscompares++;
      $display("FAIL lsl_hold: done=%b Q=%h out=%b, need 0 88 1", done, Q, shifted_out);
    end
  endtask

  task automatic test_asr();
    issue(2'b10, 3'd2, 8'b1001_0110);
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL asr_early: done=%b busy=%b, need 0 1", done, busy);
    end
    step();
    vectors++;
    if (done !== 1'b1 || Q !== 8'b1110_0101 || shifted_out !== 1'b1) begin
      miscompares++;
      $display("FAIL asr: done=%b Q=%h out=%b, need 1 e5 1", done, Q, shifted_out);
    end
    step();
  endtask

  task automatic test_by_zero();
    issue(2'b01, 3'd0, 8'hA5);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || Q !== 8'hA5 || shifted_out !== 1'b0) begin
      miscompares++;
      $display("FAIL by_zero: done=%b busy=%b Q=%h out=%b, need 1 0 a5 0", done, busy, Q, shifted_out);
    end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL by_zero_idle: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_q;
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
    exp_q = 8'h03;
`else
    exp_q = 8'h02;
`endif
    issue(2'b11, 3'd1, 8'h81);
    step();
    vectors++;
    if (done !== 1'b1 || Q !== exp_q || shifted_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rotate: done=%b Q=%h out=%b, need 1 %h 1", done, Q, shifted_out, exp_q);
    end
    step();
  endtask

  task automatic test_hazard_start();
    issue(2'b00, 3'd5, 8'h01);
    step();
    start = 1'b1; D = 8'hFF; mode = 2'b01; by = 3'd1;
    step();
    start = 1'b0;
    step(); step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || Q !== 8'h10) begin
      miscompares++;
      $display("FAIL hazard_mid: done=%b busy=%b Q=%h, need 0 1 10", done, busy, Q);
    end
    step();
    vectors++;
    if (done !== 1'b1 || Q !== 8'h20 || shifted_out !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_start: done=%b Q=%h out=%b, need 1 20 0", done, Q, shifted_out);
    end
    step();
  endtask

  task automatic test_hazard_reset();
    int dc;
    issue(2'b00, 3'd5, 8'h01);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({Q, busy, done, shifted_out} !== {8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL hazard_reset: Q=%h busy=%b done=%b out=%b, need 00 0 0 0", Q, busy, done, shifted_out);
    end
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) dc++;
    end
    vectors++;
    if (dc != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: active_cycles=%0d, need 0", dc);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 2'b00; by = 3'd1; D = 8'h3C;
    step();
    step();
    vectors++;
    if (done !== 1'b1 || Q !== 8'h78) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b Q=%h, need 1 78", done, Q);
    end
    mode = 2'b01; by = 3'd1; D = 8'h0F;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || Q !== 8'h0F || shifted_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b Q=%h out=%b, need 1 0 0f 0", busy, done, Q, shifted_out);
    end
    step();
    vectors++;
    if (done !== 1'b1 || Q !== 8'h07 || shifted_out !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: done=%b Q=%h out=%b, need 1 07 1", done, Q, shifted_out);
    end
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_lsl();
    test_asr();
    test_by_zero();
    test_rotate();
    test_hazard_start();
    test_hazard_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
